// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced two-button front end for the 4-bit ALU.
// Loads num1, num2 and opcode from the switches on successive enter presses,
// runs one exec cycle, then captures the ALU result and flags for display.
// Build option: define ACC_CHAIN_EN to chain the shown result into num1.

module alu_operand_sequencer_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          flip;

  // The level flips on the CYCLES-th consecutive disagreeing sample.
  assign flip = (sync[1] != level) && (cnt == CW'(CYCLES - 1));

  // Synchronizer, symmetric run-length filter and rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      pulse <= flip & sync[1];
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (flip) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module alu_operand_sequencer #(
  parameter int DATA_W          = 4,
  parameter int OP_W            = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] result_q,
  output logic [3:0]        flags_q,
  output logic              result_valid,
  output logic              busy,
  output logic [2:0]        state_o
);
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Bit 0 is enter, bit 1 is clear; both go through identical filters.
  logic [1:0] btn_raw, btn_pulse;
  logic       enter_p, clear_p;

  assign btn_raw = {btn_clear, btn_enter};
  assign enter_p = btn_pulse[0];
  assign clear_p = btn_pulse[1];

  for (genvar i = 0; i < 2; i++) begin : g_btn
    alu_operand_sequencer_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[i]),
      .pulse (btn_pulse[i])
    );
  end

  state_t            state, state_n;
  logic [DATA_W-1:0] num1_n, num2_n, result_n;
  logic [OP_W-1:0]   opcode_n;
  logic [3:0]        flags_n;
  logic              valid_n;

  // State and operand/result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_A;
      num1         <= '0;
      num2         <= '0;
      opcode       <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      num1         <= num1_n;
      num2         <= num2_n;
      opcode       <= opcode_n;
      result_q     <= result_n;
      flags_q      <= flags_n;
      result_valid <= valid_n;
    end
  end

  // Next-state and register loads; clear overrides anything enter does.
  always_comb begin
    state_n  = state;
    num1_n   = num1;
    num2_n   = num2;
    opcode_n = opcode;
    result_n = result_q;
    flags_n  = flags_q;
    valid_n  = result_valid;
    case (state)
      S_A:    if (enter_p) begin num1_n = sw_data; state_n = S_B; end
      S_B:    if (enter_p) begin num2_n = sw_data; state_n = S_OP; end
      S_OP:   if (enter_p) begin opcode_n = sw_data[OP_W-1:0]; state_n = S_EXEC; end
      S_EXEC: begin
        result_n = alu_result;
        flags_n  = {alu_carry, alu_overflow, alu_negative, alu_zero};
        valid_n  = 1'b1;
        state_n  = S_SHOW;
      end
      S_SHOW: if (enter_p) begin
        valid_n = 1'b0;
`ifdef ACC_CHAIN_EN
        num1_n  = result_q;
        state_n = S_B;
`else
        state_n = S_A;
`endif
      end
      default: state_n = S_A;
    endcase
    if (clear_p) begin
      state_n  = S_A;
      num1_n   = '0;
      num2_n   = '0;
      opcode_n = '0;
      result_n = '0;
      flags_n  = '0;
      valid_n  = 1'b0;
    end
  end

  assign busy    = (state == S_EXEC);
  assign state_o = state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed scenarios plus random button
// traffic, compared every cycle against a behavioural sequence model.
module tb_alu_operand_sequencer;
  localparam int D = 4;

  logic       clk, rst;
  logic [3:0] sw_data;
  logic       btn_enter, btn_clear;
  logic [3:0] num1, num2, result_q, flags_q, alu_result;
  logic [1:0] opcode;
  logic       alu_carry, alu_overflow, alu_negative, alu_zero;
  logic       result_valid, busy;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  alu_operand_sequencer #(.DATA_W(4), .OP_W(2), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .num1(num1), .num2(num2), .opcode(opcode), .alu_result(alu_result),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .result_q(result_q), .flags_q(flags_q),
    .result_valid(result_valid), .busy(busy), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {carry, overflow, negative, zero, result}.
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic c, ov;
    c = 1'b0; ov = 1'b0; s = '0;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; ov = (a[3] == b[3]) && (r[3] != a[3]); end
      2'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; ov = (a[3] != b[3]) && (r[3] != a[3]); end
      2'd2: r = a | b;
      default: r = a & b;
    endcase
    return {c, ov, r[3], (r == 4'd0), r};
  endfunction

  assign {alu_carry, alu_overflow, alu_negative, alu_zero, alu_result} = alu_f(num1, num2, opcode);

  // A button is accepted once the last D synchronized samples (raw delayed
  // by two clocks) all disagree with the accepted level.
  function automatic bit settled(input logic [31:0] h, input bit lvl);
    for (int i = 0; i < D; i++) if (h[2 + i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  logic [31:0] he, hc;
  bit          lvl_e, lvl_c, pe, pc;
  logic [2:0]  m_st;
  logic [3:0]  m_n1, m_n2, m_rq, m_fq;
  logic [1:0]  m_op;
  bit          m_rv;

  // Behavioural model: button acceptance and the operand/result sequence.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      he <= '0; hc <= '0; lvl_e <= 0; lvl_c <= 0; pe <= 0; pc <= 0;
      m_st <= 0; m_n1 <= 0; m_n2 <= 0; m_op <= 0; m_rq <= 0; m_fq <= 0; m_rv <= 0;
    end else begin
      he <= {he[30:0], btn_enter};
      hc <= {hc[30:0], btn_clear};
      if (settled({he[30:0], btn_enter}, lvl_e)) begin lvl_e <= ~lvl_e; pe <= ~lvl_e; end
      else pe <= 1'b0;
      if (settled({hc[30:0], btn_clear}, lvl_c)) begin lvl_c <= ~lvl_c; pc <= ~lvl_c; end
      else pc <= 1'b0;
      if (pc) begin
        m_st <= 0; m_n1 <= 0; m_n2 <= 0; m_op <= 0; m_rq <= 0; m_fq <= 0; m_rv <= 0;
      end else begin
        case (m_st)
          3'd0: if (pe) begin m_n1 <= sw_data; m_st <= 1; end
          3'd1: if (pe) begin m_n2 <= sw_data; m_st <= 2; end
          3'd2: if (pe) begin m_op <= sw_data[1:0]; m_st <= 3; end
          3'd3: begin
            {m_fq, m_rq} <= alu_f(m_n1, m_n2, m_op);
            m_rv <= 1'b1;
            m_st <= 4;
          end
          default: if (pe) begin
            m_rv <= 1'b0;
`ifdef ACC_CHAIN_EN
            m_n1 <= m_rq;
            m_st <= 1;
`else
            m_st <= 0;
`endif
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("state_o", 32'(state_o), 32'(m_st));
      chk("num1", 32'(num1), 32'(m_n1));
      chk("num2", 32'(num2), 32'(m_n2));
      chk("opcode", 32'(opcode), 32'(m_op));
      chk("result_q", 32'(result_q), 32'(m_rq));
      chk("flags_q", 32'(flags_q), 32'(m_fq));
      chk("result_valid", 32'(result_valid), 32'(m_rv));
      chk("busy", 32'(busy), 32'(m_st == 3'd3));
    end
  end

  // Drive one press of enter and/or clear; returns cycles busy was seen high.
  task automatic press(input logic [3:0] v, input bit e, input bit c, input int hold,
                       input int gap, output int nb);
    @(negedge clk);
    sw_data = v; btn_enter = e; btn_clear = c; nb = 0;
    repeat (hold) begin @(negedge clk); if (busy) nb++; end
    btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (gap) begin @(negedge clk); if (busy) nb++; end
  endtask

  task automatic enter(input logic [3:0] v);
    int nb;
    press(v, 1'b1, 1'b0, 6, D + 4, nb);
  endtask

  task automatic clear();
    int nb;
    press(4'd0, 1'b0, 1'b1, 6, D + 4, nb);
  endtask

  initial begin
    int nb, n;
    rst = 1'b1; sw_data = '0; btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // Reset asynchronously while in S_OP with num1 = 5.
    enter(4'd5); enter(4'd2);
    chk("pre_rst_state", 32'(state_o), 2);
    chk("pre_rst_num1", 32'(num1), 5);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("async_rst_state", 32'(state_o), 0);
    chk("async_rst_num1", 32'(num1), 0);
    chk("async_rst_num2", 32'(num2), 0);
    chk("async_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 3 + 4 with add.
    enter(4'd3); enter(4'd4); enter(4'd0);
    chk("add_num1", 32'(num1), 3);
    chk("add_num2", 32'(num2), 4);
    chk("add_opcode", 32'(opcode), 0);
    chk("add_result", 32'(result_q), 7);
    chk("add_flags", 32'(flags_q), 0);
    chk("add_valid", 32'(result_valid), 1);
    chk("add_state", 32'(state_o), 4);

    // 6 - 6 gives zero; exec lasts exactly one cycle.
    clear();
    enter(4'd6); enter(4'd6);
    press(4'd1, 1'b1, 1'b0, 6, D + 4, nb);
    chk("sub_result", 32'(result_q), 0);
    chk("sub_flags", 32'(flags_q), 4'b0001);
    chk("sub_busy_cycles", 32'(nb), 1);

    // A 3-cycle glitch must not be accepted.
    clear();
    @(negedge clk); sw_data = 4'd9; btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_state", 32'(state_o), 0);

    // Long hold: pulse 6 cycles after the rise, state moves on the next edge,
    // and only a single advance over a 40-cycle hold.
    @(negedge clk); btn_enter = 1'b1; n = 0;
    while (state_o == 3'd0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("press_to_advance", 32'(n), 7);
    repeat (33) @(negedge clk);
    btn_enter = 1'b0;
    repeat (D + 6) @(negedge clk);
    chk("hold_state", 32'(state_o), 1);
    chk("hold_num1", 32'(num1), 9);

    // Clear and enter accepted in the same cycle while showing a result.
    enter(4'd7); enter(4'd1);
    chk("show_before_clear", 32'(state_o), 4);
    press(4'd3, 1'b1, 1'b1, 6, D + 4, nb);
    chk("prio_state", 32'(state_o), 0);
    chk("prio_result", 32'(result_q), 0);
    chk("prio_valid", 32'(result_valid), 0);

    // Enter from the result display.
    enter(4'd3); enter(4'd4); enter(4'd0);
    chk("chain_base", 32'(result_q), 7);
    enter(4'd15);
`ifdef ACC_CHAIN_EN
    chk("chain_num1", 32'(num1), 7);
    chk("chain_state", 32'(state_o), 1);
    enter(4'd2); enter(4'd0);
    chk("chain_result", 32'(result_q), 9);
`else
    chk("nochain_state", 32'(state_o), 0);
    chk("nochain_num1", 32'(num1), 3);
`endif

    // Random button traffic, including short glitches and tight gaps.
    for (int i = 0; i < 300; i++) begin
      press(4'($urandom_range(0, 15)), $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(1, 8), $urandom_range(0, 9), nb);
    end

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Front-end stage that feeds the 4-bit ALU. It debounces two push-buttons, loads num1, num2 and opcode from the switches one after another, and holds them stable for the ALU. After the ALU settles it registers the ALU result and flags for display. The ALU itself stays combinational; this block supplies all sequencing.

Parameters:
DATA_W, 4, operand/result width (matches ALU)
OP_W, 2, opcode width (matches ALU)
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sw_data  in  DATA_W  switch value; sampled only on an accepted enter press (switches are quasi-static)
btn_enter  in  1  raw asynchronous enter button, active-high
btn_clear  in  1  raw asynchronous clear button, active-high
num1  out  DATA_W  registered operand A to ALU
num2  out  DATA_W  registered operand B to ALU
opcode  out  OP_W  registered opcode to ALU (00 add, 01 sub, 10 or, 11 and)
alu_result  in  DATA_W  ALU result
alu_carry, alu_overflow, alu_negative, alu_zero  in  1 each  ALU flags
result_q  out  DATA_W  captured result
flags_q  out  4  captured flags {carry, overflow, negative, zero}
result_valid  out  1  high while result_q/flags_q hold a valid capture
busy  out  1  high in S_EXEC
state_o  out  3  current state encoding

Behaviour:
- Reset (async assert, release on clk edge): state S_A; num1, num2, opcode, result_q, flags_q = 0; result_valid = 0; busy = 0; debounce state cleared (debounced level 0, counter 0, synchronizers 0).
- Each button: 2-FF synchronizer, then a symmetric debouncer. The counter increments while the synchronized level differs from the debounced level and resets to 0 on any matching cycle. At DEBOUNCE_CYCLES the debounced level flips and the counter resets.
- enter_p / clear_p: single-cycle pulse on the debounced rising edge. A held button gives exactly one pulse. A glitch shorter than DEBOUNCE_CYCLES gives none.
- Press latency: raw rise to pulse = 2 + DEBOUNCE_CYCLES cycles (+/-1 for async sampling).
- States (state_o): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4; 5-7 unreachable and recover to S_A.
  - S_A: on enter_p, num1 <= sw_data, go to S_B.
  - S_B: on enter_p, num2 <= sw_data, go to S_OP.
  - S_OP: on enter_p, opcode <= sw_data[OP_W-1:0], go to S_EXEC.
  - S_EXEC: unconditional one cycle; busy = 1. At the end of the cycle result_q <= alu_result, flags_q <= ALU flags, result_valid <= 1, go to S_SHOW. enter_p in this cycle is ignored.
  - S_SHOW: hold all outputs. On enter_p, result_valid <= 0 and go to S_A (see optional feature). num1/num2/opcode keep their old values until overwritten.
- Result latency: enter_p in S_OP at cycle k; S_EXEC in k+1; result_valid = 1 from k+2.
- clear_p (any state): state S_A; num1, num2, opcode, result_q, flags_q = 0; result_valid = 0. clear_p beats enter_p in the same cycle.
- No arithmetic is done here; width truncation of sw_data to OP_W takes the low bits.

Optional Feature:
ACC_CHAIN_EN: when defined, enter_p in S_SHOW loads num1 <= result_q, clears result_valid and goes to S_B. This chains the previous result as the next operand A. When undefined, S_SHOW goes to S_A as above. Clear behaviour is the same either way.

Test Plan:
- Reset mid-sequence (in S_OP, num1=5): assert rst -> same cycle all outputs 0, state_o=0, no clk edge required.
- Full add (DEBOUNCE_CYCLES=4): enter with sw 3, 4, 0 -> num1=3, num2=4, opcode=00; result_valid rises 2 cycles after the opcode pulse; result_q=7, flags_q=0000.
- Sub to zero: 6, 6, op 01 -> result_q=0, flags_q zero bit=1; busy high exactly one cycle.
- Debounce: a 3-cycle enter glitch gives no state change; a 40-cycle hold gives exactly one advance; the press-to-pulse delay is 6 cycles.
- Clear priority: in S_SHOW, clear and enter pulse in the same cycle -> state_o=0, result_q=0, result_valid=0.
- ACC_CHAIN_EN: result 7 shown, press enter -> num1=7, state_o=1. Then enter 2 and op 00 -> result_q=9. Without the macro, the same press gives state_o=0 and num1 stays 3.
